// File: rtl/cam_frame_capture_if.sv
// Camera input bus, capture control and frame-buffer write port for cam_frame_capture.
// CAPTURE_TESTPAT_EN adds the testpat select line.
`timescale 1ns/1ps
interface cam_frame_capture_if #(
  parameter int ADDR_W = 17
) ();
  logic              capture_en;
  logic              cam_pclk;
  logic              cam_vsync;
  logic              cam_href;
  logic [7:0]        cam_data;
`ifdef CAPTURE_TESTPAT_EN
  logic              testpat;
`endif
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [11:0]       wr_data;
  logic              ready_display;
  logic              frame_done;
  logic              frame_error;

  modport master (
`ifdef CAPTURE_TESTPAT_EN
    input  testpat,
`endif
    input  capture_en, cam_pclk, cam_vsync, cam_href, cam_data,
    output wr_en, wr_addr, wr_data, ready_display, frame_done, frame_error
  );

  modport slave (
`ifdef CAPTURE_TESTPAT_EN
    output testpat,
`endif
    output capture_en, cam_pclk, cam_vsync, cam_href, cam_data,
    input  wr_en, wr_addr, wr_data, ready_display, frame_done, frame_error
  );
endinterface

// File: rtl/cam_frame_capture.sv
// OV7670-style RGB444 capture into a linear frame buffer, with optional 2:1 decimation.
// Define CAPTURE_TESTPAT_EN to add a vertical colour-bar test pattern on testpat.
`timescale 1ns/1ps
module cam_frame_capture #(
  parameter int H_RES    = 320,
  parameter int V_RES    = 240,
  parameter int ADDR_W   = 17,
  parameter int DECIMATE = 1
) (
  input logic sys_clk,
  input logic reset,
  cam_frame_capture_if.master bus
);
  localparam logic [ADDR_W-1:0] TOTAL = ADDR_W'(H_RES * V_RES);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ARMED   = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [2:0]        pclk_sync_r, vsync_sync_r;
  logic [1:0]        href_sync_r;
  logic [7:0]        data_q1_r, data_q2_r;
  logic              href_prev_r, phase_r, ovf_r;
  logic [3:0]        red_r;
  logic [15:0]       col_r, line_r;
  logic [ADDR_W-1:0] addr_cnt_r, wr_addr_r;
  logic [11:0]       wr_data_r, pix_data_s;
  logic              wr_en_r, ready_r, done_r, err_r;
  logic              pclk_rise_s, vs_rise_s, vs_fall_s, start_s, end_s;
  logic              byte_s, eff_phase_s, pixel_s, keep_s, href_fall_s, err_s;

  // Two-flop synchronisers; bit 2 of pclk/vsync is the edge-detect tap
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      pclk_sync_r  <= 3'd0;
      vsync_sync_r <= 3'd0;
      href_sync_r  <= 2'd0;
      data_q1_r    <= 8'd0;
      data_q2_r    <= 8'd0;
      href_prev_r  <= 1'b0;
    end else begin
      pclk_sync_r  <= {pclk_sync_r[1:0], bus.cam_pclk};
      vsync_sync_r <= {vsync_sync_r[1:0], bus.cam_vsync};
      href_sync_r  <= {href_sync_r[0], bus.cam_href};
      data_q1_r    <= bus.cam_data;
      data_q2_r    <= data_q1_r;
      if (pclk_rise_s) begin
        href_prev_r <= href_sync_r[1];
      end
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_r <= WAIT_VS;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state plus per-cycle byte/pixel/frame event decode
  always_comb begin
    state_s     = state_r;
    start_s     = 1'b0;
    end_s       = 1'b0;
    pclk_rise_s = pclk_sync_r[1] & ~pclk_sync_r[2];
    vs_rise_s   = vsync_sync_r[1] & ~vsync_sync_r[2];
    vs_fall_s   = ~vsync_sync_r[1] & vsync_sync_r[2];
    case (state_r)
      WAIT_VS: begin
        if (vsync_sync_r[1]) state_s = ARMED;
        else                 state_s = WAIT_VS;
      end
      ARMED: begin
        if (vs_fall_s && bus.capture_en) begin
          state_s = ACTIVE;
          start_s = 1'b1;
        end else begin
          state_s = ARMED;
        end
      end
      ACTIVE: begin
        if (vs_rise_s) begin
          state_s = ARMED;
          end_s   = 1'b1;
        end else begin
          state_s = ACTIVE;
        end
      end
      default: state_s = WAIT_VS;
    endcase
    byte_s      = (state_r == ACTIVE) & pclk_rise_s & href_sync_r[1];
    href_fall_s = (state_r == ACTIVE) & pclk_rise_s & ~href_sync_r[1] & href_prev_r;
    // The first byte after href rises is always phase 0
    eff_phase_s = href_prev_r & phase_r;
    pixel_s     = byte_s & eff_phase_s;
    keep_s      = pixel_s & ((DECIMATE == 0) | (~col_r[0] & ~line_r[0]));
    err_s       = (addr_cnt_r != TOTAL) | ovf_r;
  end

`ifdef CAPTURE_TESTPAT_EN
  localparam int BAR_WIDTH = (H_RES / 8 > 0) ? (H_RES / 8) : 1;
  logic [15:0] col_idx_s, bar_full_s;
  logic [2:0]  bar_s;

  // Colour-bar generator indexed by stored column
  always_comb begin
    col_idx_s  = (DECIMATE != 0) ? {1'b0, col_r[15:1]} : col_r;
    bar_full_s = col_idx_s / 16'(BAR_WIDTH);
    if (bar_full_s > 16'd7) bar_s = 3'd7;
    else                    bar_s = bar_full_s[2:0];
    if (bus.testpat) pix_data_s = {{4{bar_s[2]}}, {4{bar_s[1]}}, {4{bar_s[0]}}};
    else             pix_data_s = {red_r, data_q2_r};
  end
`else
  assign pix_data_s = {red_r, data_q2_r};
`endif

  // Byte assembly, line/column counting, write strobe and frame status
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      phase_r    <= 1'b0;
      red_r      <= 4'd0;
      col_r      <= 16'd0;
      line_r     <= 16'd0;
      addr_cnt_r <= '0;
      ovf_r      <= 1'b0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= 12'd0;
      ready_r    <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      if (start_s) begin
        phase_r    <= 1'b0;
        col_r      <= 16'd0;
        line_r     <= 16'd0;
        addr_cnt_r <= '0;
        ovf_r      <= 1'b0;
      end else begin
        if (byte_s) begin
          if (!eff_phase_s) begin
            red_r   <= data_q2_r[3:0];
            phase_r <= 1'b1;
            if (!href_prev_r) col_r <= 16'd0;
          end else begin
            phase_r <= 1'b0;
            col_r   <= col_r + 16'd1;
          end
        end
        if (href_fall_s) line_r <= line_r + 16'd1;
        // Once the buffer is full, kept pixels are dropped and remembered as overflow
        if (keep_s) begin
          if (addr_cnt_r != TOTAL) begin
            wr_en_r    <= 1'b1;
            wr_addr_r  <= addr_cnt_r;
            wr_data_r  <= pix_data_s;
            addr_cnt_r <= addr_cnt_r + ADDR_W'(1);
          end else begin
            ovf_r <= 1'b1;
          end
        end
        if (end_s) begin
          done_r  <= 1'b1;
          err_r   <= err_s;
          ready_r <= ready_r | ~err_s;
        end
      end
    end
  end

  assign bus.wr_en         = wr_en_r;
  assign bus.wr_addr       = wr_addr_r;
  assign bus.wr_data       = wr_data_r;
  assign bus.ready_display = ready_r;
  assign bus.frame_done    = done_r;
  assign bus.frame_error   = err_r;
endmodule
